inst_fetch: RTL and testbench



---
 rtl/inst_fetch.sv | 117 +++++++++++
 tb/tb_inst_fetch.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/inst_fetch.sv
// Instruction fetch unit: one 64-bit read per instruction, 32-bit word picked by pc[2],
// handed to the decoder over valid/ready; execute-stage redirects squash in-flight fetches.
module inst_fetch #(
    parameter logic [63:0] RESET_PC = 64'h8000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic [63:0] araddr,
    output logic        arvalid,
    input  logic        arready,
    input  logic [63:0] rdata,
    input  logic [1:0]  rresp,
    input  logic        rvalid,
    output logic        rready,
    output logic [31:0] inst,
    output logic [63:0] inst_pc,
    output logic        inst_fault,
    output logic        inst_valid,
    input  logic        inst_ready,
    input  logic        jup,
    input  logic [63:0] dnpc
);

    typedef enum logic [1:0] {IDLE, REQ, RESP, HOLD} state_t;

    state_t      state;
    logic [63:0] pc;
    logic        drop;
    logic [63:0] redirect_pc;
    logic [63:0] seq_pc;

    function automatic logic [31:0] select_word(input logic [63:0] data,
                                                input logic        upper,
                                                input logic        fault);
        if (fault)
            return 32'h0;
        return upper ? data[63:32] : data[31:0];
    endfunction

    // A redirect always overrides both the current pc and the sequential successor.
    always_comb begin
        redirect_pc = pc;
        seq_pc      = pc + 64'd4;
        if (jup) begin
            redirect_pc = dnpc;
            seq_pc      = dnpc;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= IDLE;
            pc         <= RESET_PC;
            drop       <= 1'b0;
            araddr     <= {RESET_PC[63:3], 3'b000};
            arvalid    <= 1'b0;
            rready     <= 1'b0;
            inst       <= 32'h0;
            inst_pc    <= RESET_PC;
            inst_fault <= 1'b0;
            inst_valid <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    pc      <= redirect_pc;
                    araddr  <= {redirect_pc[63:3], 3'b000};
                    arvalid <= 1'b1;
                    state   <= REQ;
                end
                REQ: begin
                    // The read cannot be withdrawn; remember the target and discard its data later.
                    if (jup) begin
                        pc   <= dnpc;
                        drop <= 1'b1;
                    end
                    if (arready) begin
                        arvalid <= 1'b0;
                        rready  <= 1'b1;
                        state   <= RESP;
                    end
                end
                RESP: begin
                    if (rvalid) begin
                        rready <= 1'b0;
                        if (drop || jup) begin
                            pc      <= redirect_pc;
                            araddr  <= {redirect_pc[63:3], 3'b000};
                            arvalid <= 1'b1;
                            drop    <= 1'b0;
                            state   <= REQ;
                        end else begin
                            inst       <= select_word(rdata, pc[2], rresp != 2'b00);
                            inst_pc    <= pc;
                            inst_fault <= (rresp != 2'b00);
                            inst_valid <= 1'b1;
                            state      <= HOLD;
                        end
                    end else if (jup) begin
                        pc   <= dnpc;
                        drop <= 1'b1;
                    end
                end
                HOLD: begin
                    if (jup || inst_ready) begin
                        pc         <= seq_pc;
                        araddr     <= {seq_pc[63:3], 3'b000};
                        arvalid    <= 1'b1;
                        inst_valid <= 1'b0;
                        state      <= REQ;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_inst_fetch.sv
// Bench for inst_fetch: cycle table, directed redirect/fault/reset sequences,
// then randomized bus and decoder timing against an instruction-stream reference model.
module tb_inst_fetch;

    localparam logic [63:0] RST_PC = 64'h8000_0000;

    logic        clk;
    logic        rst_n;
    logic [63:0] araddr;
    logic        arvalid;
    logic        arready;
    logic [63:0] rdata;
    logic [1:0]  rresp;
    logic        rvalid;
    logic        rready;
    logic [31:0] inst;
    logic [63:0] inst_pc;
    logic        inst_fault;
    logic        inst_valid;
    logic        inst_ready;
    logic        jup;
    logic [63:0] dnpc;

    inst_fetch #(.RESET_PC(RST_PC)) dut (
        .clk(clk), .rst_n(rst_n),
        .araddr(araddr), .arvalid(arvalid), .arready(arready),
        .rdata(rdata), .rresp(rresp), .rvalid(rvalid), .rready(rready),
        .inst(inst), .inst_pc(inst_pc), .inst_fault(inst_fault),
        .inst_valid(inst_valid), .inst_ready(inst_ready),
        .jup(jup), .dnpc(dnpc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // Memory slave state
    logic        pending = 1'b0;
    logic [63:0] pend_addr = 64'h0;
    logic        hold_r = 1'b0;
    logic        ar_rand = 1'b0;
    logic        r_rand = 1'b0;

    // Reference model state
    logic        model_on = 1'b0;
    logic [63:0] exp_pc = 64'h0;
    int          accepted = 0;

    typedef struct {
        logic        rdy;
        logic        jp;
        logic [63:0] np;
        logic        av;
        logic        rr;
        logic        iv;
        logic [63:0] ad;
        logic [31:0] in;
        logic [63:0] ipc;
    } vec_t;

    vec_t tbl [17];

    function automatic logic [31:0] word32(input logic [63:0] a);
        return a[31:0] ^ 32'h5A5A_0003;
    endfunction

    function automatic logic [63:0] mem_data(input logic [63:0] a);
        if (a == 64'h8000_0000)
            return 64'h0010_0073_0000_0413;
        return {word32(a + 64'd4), word32(a)};
    endfunction

    function automatic logic [1:0] mem_resp(input logic [63:0] a);
        case (a[11:8])
            4'hF:    return 2'b10;
            4'hE:    return 2'b01;
            default: return 2'b00;
        endcase
    endfunction

    function automatic logic [31:0] exp_inst(input logic [63:0] pc);
        logic [63:0] line;
        logic [63:0] d;
        line = {pc[63:3], 3'b000};
        if (mem_resp(line) != 2'b00)
            return 32'h0;
        d = mem_data(line);
        return pc[2] ? d[63:32] : d[31:0];
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
        n_checks++;
        if (act !== req) begin
            n_errors++;
            $display("FAIL %s: got %h, expected %h", nm, act, req);
        end
    endtask

    task automatic tick();
        logic        p_av, p_ar, p_rr, p_rv, p_iv, p_ir, p_flt, p_jup, p_rst;
        logic [63:0] p_addr, p_ipc, p_dnpc;
        logic [31:0] p_inst;
        arready = ar_rand ? ($urandom_range(0, 2) != 0) : 1'b1;
        rvalid  = pending && !hold_r && (r_rand ? ($urandom_range(0, 1) == 1) : 1'b1);
        rdata   = rvalid ? mem_data(pend_addr) : {$urandom, $urandom};
        rresp   = rvalid ? mem_resp(pend_addr) : 2'b11;
        p_av = arvalid; p_ar = arready; p_addr = araddr; p_rr = rready; p_rv = rvalid;
        p_iv = inst_valid; p_ir = inst_ready; p_inst = inst; p_ipc = inst_pc;
        p_flt = inst_fault; p_jup = jup; p_dnpc = dnpc; p_rst = rst_n;
        @(posedge clk);
        #1;
        if (!p_rst) begin
            pending = 1'b0;
        end else begin
            if (p_rv && p_rr)
                pending = 1'b0;
            if (p_av && p_ar) begin
                chk("single_outstanding", {63'h0, pending}, 64'h0);
                pending   = 1'b1;
                pend_addr = p_addr;
            end
        end
        if (model_on && p_rst) begin
            if (p_iv && p_ir) begin
                accepted++;
                chk("model_inst_pc", p_ipc, exp_pc);
                chk("model_inst", {32'h0, p_inst}, {32'h0, exp_inst(exp_pc)});
                chk("model_fault", {63'h0, p_flt},
                    {63'h0, mem_resp({exp_pc[63:3], 3'b000}) != 2'b00});
                exp_pc = exp_pc + 64'd4;
            end
            if (p_jup)
                exp_pc = p_dnpc;
            if (p_iv && !p_ir && !p_jup) begin
                chk("stall_valid", {63'h0, inst_valid}, 64'h1);
                chk("stall_inst", {32'h0, inst}, {32'h0, p_inst});
                chk("stall_pc", inst_pc, p_ipc);
                chk("stall_no_ar", {63'h0, arvalid}, 64'h0);
            end
            if (p_av && !p_ar) begin
                chk("ar_hold_valid", {63'h0, arvalid}, 64'h1);
                chk("ar_hold_addr", araddr, p_addr);
            end
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0; inst_ready = 1'b0; jup = 1'b0; dnpc = 64'h0; hold_r = 1'b0;
        tick();
        tick();
    endtask

    task automatic check_reset(input string nm);
        chk({nm, "_arvalid"}, {63'h0, arvalid}, 64'h0);
        chk({nm, "_rready"}, {63'h0, rready}, 64'h0);
        chk({nm, "_inst_valid"}, {63'h0, inst_valid}, 64'h0);
        chk({nm, "_inst"}, {32'h0, inst}, 64'h0);
        chk({nm, "_fault"}, {63'h0, inst_fault}, 64'h0);
        chk({nm, "_inst_pc"}, inst_pc, RST_PC);
        chk({nm, "_araddr"}, araddr, {RST_PC[63:3], 3'b000});
    endtask

    task automatic wait_valid(input string nm);
        for (int k = 0; k < 40 && !inst_valid; k++)
            tick();
        chk(nm, {63'h0, inst_valid}, 64'h1);
    endtask

    initial begin
        rst_n = 1'b0; arready = 1'b0; rdata = 64'h0; rresp = 2'b00; rvalid = 1'b0;
        inst_ready = 1'b0; jup = 1'b0; dnpc = 64'h0;

        tbl[0]  = '{1'b1, 1'b0, 64'h0, 1'b1, 1'b0, 1'b0, RST_PC, 32'h0, RST_PC};
        tbl[1]  = '{1'b1, 1'b0, 64'h0, 1'b0, 1'b1, 1'b0, RST_PC, 32'h0, RST_PC};
        tbl[2]  = '{1'b1, 1'b0, 64'h0, 1'b0, 1'b0, 1'b1, RST_PC, 32'h0000_0413, RST_PC};
        tbl[3]  = '{1'b1, 1'b0, 64'h0, 1'b1, 1'b0, 1'b0, RST_PC, 32'h0000_0413, RST_PC};
        tbl[4]  = '{1'b1, 1'b0, 64'h0, 1'b0, 1'b1, 1'b0, RST_PC, 32'h0000_0413, RST_PC};
        tbl[5]  = '{1'b1, 1'b0, 64'h0, 1'b0, 1'b0, 1'b1, RST_PC, 32'h0010_0073, RST_PC + 4};
        tbl[6]  = '{1'b1, 1'b0, 64'h0, 1'b1, 1'b0, 1'b0, RST_PC + 8, 32'h0010_0073, RST_PC + 4};
        tbl[7]  = '{1'b1, 1'b0, 64'h0, 1'b0, 1'b1, 1'b0, RST_PC + 8, 32'h0010_0073, RST_PC + 4};
        for (int i = 8; i < 14; i++)
            tbl[i] = '{1'b0, 1'b0, 64'h0, 1'b0, 1'b0, 1'b1, RST_PC + 8, 32'hDA5A_000B, RST_PC + 8};
        tbl[14] = '{1'b1, 1'b1, 64'h8000_0040, 1'b1, 1'b0, 1'b0, 64'h8000_0040, 32'hDA5A_000B, RST_PC + 8};
        tbl[15] = '{1'b1, 1'b0, 64'h0, 1'b0, 1'b1, 1'b0, 64'h8000_0040, 32'hDA5A_000B, RST_PC + 8};
        tbl[16] = '{1'b1, 1'b0, 64'h0, 1'b0, 1'b0, 1'b1, 64'h8000_0040, 32'hDA5A_0043, 64'h8000_0040};

        // Reset values, then the zero-wait cycle table
        do_reset();
        check_reset("reset");
        rst_n = 1'b1;
        for (int i = 0; i < 17; i++) begin
            inst_ready = tbl[i].rdy;
            jup        = tbl[i].jp;
            dnpc       = tbl[i].np;
            tick();
            chk($sformatf("tbl%0d_arvalid", i), {63'h0, arvalid}, {63'h0, tbl[i].av});
            chk($sformatf("tbl%0d_rready", i), {63'h0, rready}, {63'h0, tbl[i].rr});
            chk($sformatf("tbl%0d_inst_valid", i), {63'h0, inst_valid}, {63'h0, tbl[i].iv});
            chk($sformatf("tbl%0d_araddr", i), araddr, tbl[i].ad);
            chk($sformatf("tbl%0d_inst", i), {32'h0, inst}, {32'h0, tbl[i].in});
            chk($sformatf("tbl%0d_inst_pc", i), inst_pc, tbl[i].ipc);
        end
        jup = 1'b0;

        // Redirect while in RESP; the response arrives three cycles later
        do_reset();
        rst_n = 1'b1; inst_ready = 1'b1;
        tick();
        tick();
        chk("resp_jup_in_resp", {63'h0, rready}, 64'h1);
        hold_r = 1'b1; jup = 1'b1; dnpc = 64'h8000_0100;
        tick();
        jup = 1'b0;
        tick();
        chk("resp_jup_valid_a", {63'h0, inst_valid}, 64'h0);
        tick();
        chk("resp_jup_valid_b", {63'h0, inst_valid}, 64'h0);
        hold_r = 1'b0;
        tick();
        chk("resp_jup_discard", {63'h0, inst_valid}, 64'h0);
        chk("resp_jup_arvalid", {63'h0, arvalid}, 64'h1);
        chk("resp_jup_araddr", araddr, 64'h8000_0100);
        wait_valid("resp_jup_wait");
        chk("resp_jup_inst_pc", inst_pc, 64'h8000_0100);
        chk("resp_jup_inst", {32'h0, inst}, 64'hDA5A_0103);

        // Redirect into a faulting region from HOLD
        inst_ready = 1'b0; jup = 1'b1; dnpc = 64'h8000_0F04;
        tick();
        jup = 1'b0;
        chk("hold_jup_drop", {63'h0, inst_valid}, 64'h0);
        chk("hold_jup_araddr", araddr, 64'h8000_0F00);
        wait_valid("fault_wait");
        chk("fault_flag", {63'h0, inst_fault}, 64'h1);
        chk("fault_inst", {32'h0, inst}, 64'h0);
        chk("fault_pc", inst_pc, 64'h8000_0F04);
        tick();
        tick();
        chk("fault_held", {63'h0, inst_valid}, 64'h1);
        inst_ready = 1'b1;
        tick();
        chk("fault_next_araddr", araddr, 64'h8000_0F08);
        wait_valid("fault_next_wait");
        chk("fault_next_pc", inst_pc, 64'h8000_0F08);

        // Reset asserted in RESP with a response being offered
        do_reset();
        rst_n = 1'b1; inst_ready = 1'b1;
        tick();
        hold_r = 1'b1;
        tick();
        rst_n = 1'b0; hold_r = 1'b0;
        tick();
        check_reset("mid_reset");
        rst_n = 1'b1;
        tick();
        chk("restart_arvalid", {63'h0, arvalid}, 64'h1);
        chk("restart_araddr", araddr, RST_PC);
        wait_valid("restart_wait");
        chk("restart_pc", inst_pc, RST_PC);
        chk("restart_inst", {32'h0, inst}, 64'h0000_0413);

        // Randomized bus, decoder and redirect timing against the reference model
        do_reset();
        exp_pc = RST_PC; model_on = 1'b1; ar_rand = 1'b1; r_rand = 1'b1;
        rst_n = 1'b1;
        for (int i = 0; i < 3000; i++) begin
            inst_ready = ($urandom_range(0, 3) != 0);
            jup        = ($urandom_range(0, 24) == 0);
            if ($urandom_range(0, 15) == 0)
                dnpc = 64'hFFFF_FFFF_FFFF_FFF8;
            else
                dnpc = 64'h8000_0000 + {32'h0, $urandom & 32'h0000_0FFC};
            tick();
        end
        model_on = 1'b0;
        jup = 1'b0;
        chk("random_progress", {63'h0, accepted >= 100}, 64'h1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
